// File: rtl/sad_block_search.sv
// Block-matching SAD engine: stores one current macroblock, streams reference
// candidates row by row, and reports full/quadrant SADs plus the best candidate.
module sad_block_search #(
    parameter int MACRO_DIM = 16,
    parameter int PIXEL_W   = 8,
    parameter int NUM_CAND  = 1024,
    parameter int CAND_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    parameter int SAD_W     = PIXEL_W + 2 * $clog2(MACRO_DIM),
    parameter int QSAD_W    = PIXEL_W + 2 * $clog2(MACRO_DIM / 2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic [PIXEL_W*MACRO_DIM-1:0]   cur_row,
    input  logic                           ref_valid,
    output logic                           ref_ready,
    input  logic [PIXEL_W*MACRO_DIM-1:0]   ref_row,
    output logic                           sad_valid,
    output logic [SAD_W-1:0]               sad,
    output logic [4*QSAD_W-1:0]            sad_quad,
    output logic [CAND_W-1:0]              sad_idx,
    output logic                           best_valid,
    output logic [SAD_W-1:0]               best_sad,
    output logic [CAND_W-1:0]              best_idx,
    output logic                           busy
);

    localparam int ROW_W  = $clog2(MACRO_DIM);
    localparam int HALF   = MACRO_DIM / 2;
    localparam int HALF_W = PIXEL_W + $clog2(HALF);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [CAND_W-1:0]              cand_q, cand_d;
    logic [PIXEL_W*MACRO_DIM-1:0]   cur_mem [MACRO_DIM];
    logic [PIXEL_W*MACRO_DIM-1:0]   cur_sel;

    logic                           s1_valid_q, s1_valid_d;
    logic                           s1_first_q, s1_first_d;
    logic                           s1_top_q, s1_top_d;
    logic                           s1_last_q, s1_last_d;
    logic [CAND_W-1:0]              s1_idx_q, s1_idx_d;
    logic [HALF_W-1:0]              s1_left_q, s1_left_d;
    logic [HALF_W-1:0]              s1_right_q, s1_right_d;

    logic [3:0][QSAD_W-1:0]         acc_q, acc_d;
    logic                           sad_valid_q, sad_valid_d;
    logic [CAND_W-1:0]              sad_idx_q, sad_idx_d;
    logic [SAD_W-1:0]               best_sad_q, best_sad_d;
    logic [CAND_W-1:0]              best_idx_q, best_idx_d;
    logic                           best_valid_q, best_valid_d;

    logic cur_fire, ref_fire, last_row, last_cand;

    function automatic logic [PIXEL_W-1:0] abs_diff(input logic [PIXEL_W-1:0] a,
                                                    input logic [PIXEL_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    assign cur_ready = (state_q == LOAD);
    assign ref_ready = (state_q == SEARCH);
    assign busy      = (state_q != IDLE);
    assign cur_fire  = cur_valid && cur_ready;
    assign ref_fire  = ref_valid && ref_ready;
    assign last_row  = (row_q == ROW_W'(MACRO_DIM - 1));
    assign last_cand = (cand_q == CAND_W'(NUM_CAND - 1));

    assign sad        = SAD_W'(acc_q[0]) + SAD_W'(acc_q[1]) + SAD_W'(acc_q[2]) + SAD_W'(acc_q[3]);
    assign sad_quad   = acc_q;
    assign sad_valid  = sad_valid_q;
    assign sad_idx    = sad_idx_q;
    assign best_valid = best_valid_q;
    assign best_sad   = best_sad_q;
    assign best_idx   = best_idx_q;

    // NOTE: the pixel store has no reset; it is always fully rewritten in LOAD before any read.
    always_ff @(posedge clk) begin
        if (cur_fire) cur_mem[row_q] <= cur_row;
    end

    // Stage 1: per-pixel absolute differences folded into left/right half-row sums.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cur_sel    = cur_mem[row_q];
        s1_left_d  = '0;
        s1_right_d = '0;
        for (int j = 0; j < HALF; j++) begin
            s1_left_d  = s1_left_d + HALF_W'(abs_diff(ref_row[j*PIXEL_W +: PIXEL_W],
                                                      cur_sel[j*PIXEL_W +: PIXEL_W]));
            s1_right_d = s1_right_d + HALF_W'(abs_diff(ref_row[(j+HALF)*PIXEL_W +: PIXEL_W],
                                                       cur_sel[(j+HALF)*PIXEL_W +: PIXEL_W]));
        end
        s1_valid_d = ref_fire;
        s1_first_d = (row_q == '0);
        s1_top_d   = (row_q < ROW_W'(HALF));
        s1_last_d  = last_row;
        s1_idx_d   = cand_q;
    end

    // Stage 2: quadrant accumulation; the first row of a candidate reloads instead of adding.
    always_comb begin
        acc_d = acc_q;
        if (s1_valid_q) begin
            if (s1_first_q) acc_d = '0;
            if (s1_top_q) begin
                acc_d[0] = acc_d[0] + QSAD_W'(s1_left_q);
                acc_d[1] = acc_d[1] + QSAD_W'(s1_right_q);
            end else begin
                acc_d[2] = acc_d[2] + QSAD_W'(s1_left_q);
                acc_d[3] = acc_d[3] + QSAD_W'(s1_right_q);
            end
        end
        sad_valid_d = s1_valid_q && s1_last_q;
        sad_idx_d   = sad_valid_d ? s1_idx_q : sad_idx_q;
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cand_d       = cand_q;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        // Strict compare keeps the earlier (lower-index) candidate on ties.
        if (sad_valid_q && (sad < best_sad_q)) begin
            best_sad_d = sad;
            best_idx_d = sad_idx_q;
        end
        case (state_q)
            IDLE: if (start) begin
                state_d      = LOAD;
                row_d        = '0;
                cand_d       = '0;
                best_valid_d = 1'b0;
                best_sad_d   = '1;
            end
            LOAD: if (cur_fire) begin
                row_d = row_q + 1'b1;
                if (last_row) state_d = SEARCH;
            end
            SEARCH: if (ref_fire) begin
                row_d = row_q + 1'b1;
                if (last_row) begin
                    cand_d = cand_q + 1'b1;
                    if (last_cand) state_d = DRAIN;
                end
            end
            DRAIN: if (sad_valid_q) begin
                state_d      = IDLE;
                best_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            cand_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_top_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_idx_q     <= '0;
            s1_left_q    <= '0;
            s1_right_q   <= '0;
            acc_q        <= '0;
            sad_valid_q  <= 1'b0;
            sad_idx_q    <= '0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cand_q       <= cand_d;
            s1_valid_q   <= s1_valid_d;
            s1_first_q   <= s1_first_d;
            s1_top_q     <= s1_top_d;
            s1_last_q    <= s1_last_d;
            s1_idx_q     <= s1_idx_d;
            s1_left_q    <= s1_left_d;
            s1_right_q   <= s1_right_d;
            acc_q        <= acc_d;
            sad_valid_q  <= sad_valid_d;
            sad_idx_q    <= sad_idx_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
        end
    end

endmodule

// File: tb/tb_sad_block_search.sv
// Self-checking bench for sad_block_search: pixel arrays feed a plain-arithmetic
// SAD model and a timed scoreboard compared against the DUT every cycle.
module tb_sad_block_search;

    localparam int MD = 16;
    localparam int PW = 8;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int SW = 16;
    localparam int QW = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic              cur_valid = 1'b0;
    logic              cur_ready;
    logic [PW*MD-1:0]  cur_row = '0;
    logic              ref_valid = 1'b0;
    logic              ref_ready;
    logic [PW*MD-1:0]  ref_row = '0;
    logic              sad_valid;
    logic [SW-1:0]     sad;
    logic [4*QW-1:0]   sad_quad;
    logic [CW-1:0]     sad_idx;
    logic              best_valid;
    logic [SW-1:0]     best_sad;
    logic [CW-1:0]     best_idx;
    logic              busy;

    sad_block_search #(.MACRO_DIM(MD), .PIXEL_W(PW), .NUM_CAND(NC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_row(cur_row),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_row(ref_row),
        .sad_valid(sad_valid), .sad(sad), .sad_quad(sad_quad), .sad_idx(sad_idx),
        .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int              due;
        int              idx;
        logic [SW-1:0]   sad;
        logic [4*QW-1:0] quad;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            head;
    logic [7:0]      cur_px [MD][MD];
    logic [7:0]      ref_px [NC][MD][MD];
    logic [SW-1:0]   got_sad  [NC];
    logic [4*QW-1:0] got_quad [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: SAD by quadrant location, straight from pixel arrays.
    task automatic model_sad(input int k, output logic [SW-1:0] s, output logic [4*QW-1:0] q);
        int qs[4];
        int a, b, total;
        for (int i = 0; i < 4; i++) qs[i] = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                a = cur_px[r][c];
                b = ref_px[k][r][c];
                qs[(r >= MD/2 ? 2 : 0) + (c >= MD/2 ? 1 : 0)] += (a > b) ? a - b : b - a;
            end
        total = qs[0] + qs[1] + qs[2] + qs[3];
        s = SW'(total);
        q = {QW'(qs[3]), QW'(qs[2]), QW'(qs[1]), QW'(qs[0])};
    endtask

    task automatic model_best(output logic [SW-1:0] bs, output int bi);
        logic [SW-1:0]   s;
        logic [4*QW-1:0] q;
        bs = '1;
        bi = 0;
        for (int k = 0; k < NC; k++) begin
            model_sad(k, s, q);
            if (s < bs) begin
                bs = s;
                bi = k;
            end
        end
    endtask

    function automatic logic [PW*MD-1:0] pack_cur(input int r);
        logic [PW*MD-1:0] v;
        for (int c = 0; c < MD; c++) v[c*PW +: PW] = cur_px[r][c];
        return v;
    endfunction

    function automatic logic [PW*MD-1:0] pack_ref(input int k, input int r);
        logic [PW*MD-1:0] v;
        for (int c = 0; c < MD; c++) v[c*PW +: PW] = ref_px[k][r][c];
        return v;
    endfunction

    // Scoreboard: a pulse is required exactly on its due cycle and nowhere else.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                head = exp_q.pop_front();
                check("sad_valid_pulse", sad_valid, 1);
                check("sad", sad, head.sad);
                check("sad_quad", sad_quad, head.quad);
                check("sad_idx", sad_idx, head.idx);
                got_sad[head.idx]  = sad;
                got_quad[head.idx] = sad_quad;
            end else begin
                check("sad_valid_quiet", sad_valid, 0);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_sad_valid"}, sad_valid, 0);
        check({tag, "_sad"}, sad, 0);
        check({tag, "_sad_quad"}, sad_quad, 0);
        check({tag, "_sad_idx"}, sad_idx, 0);
        check({tag, "_best_valid"}, best_valid, 0);
        check({tag, "_best_sad"}, best_sad, 0);
        check({tag, "_best_idx"}, best_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cur_ready"}, cur_ready, 0);
        check({tag, "_ref_ready"}, ref_ready, 0);
    endtask

    task automatic clear_got();
        for (int k = 0; k < NC; k++) begin
            got_sad[k]  = '1;
            got_quad[k] = '1;
        end
    endtask

    task automatic run_search(input bit gaps, input bit noise, input int abort_rows);
        int            r, k, acc, guard, last_t, bi;
        logic [SW-1:0] bs;
        exp_t          e;
        clear_got();
        @(negedge clk);
        check("idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_cur_ready", cur_ready, 1);
        check("load_best_valid", best_valid, 0);
        r = 0;
        guard = 0;
        while (r < MD && guard < 2000) begin
            cur_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            cur_row   = pack_cur(r);
            ref_valid = 1'($urandom_range(0, 1));
            ref_row   = {$urandom, $urandom, $urandom, $urandom};
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cur_valid && cur_ready) r++;
            @(negedge clk);
            guard++;
        end
        cur_valid = 1'b0;
        ref_valid = 1'b0;
        check("load_rows", r, MD);
        r = 0;
        k = 0;
        acc = 0;
        guard = 0;
        last_t = cyc;
        while (k < NC && guard < 4000) begin
            ref_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ref_row   = pack_ref(k, r);
            cur_valid = 1'($urandom_range(0, 1));
            cur_row   = {$urandom, $urandom, $urandom, $urandom};
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ref_valid && ref_ready) begin
                acc++;
                if (r == MD - 1) begin
                    model_sad(k, e.sad, e.quad);
                    e.idx = k;
                    e.due = cyc + 2;
                    exp_q.push_back(e);
                    last_t = cyc;
                    r = 0;
                    k++;
                end else begin
                    r++;
                end
            end
            @(negedge clk);
            guard++;
            if (abort_rows > 0 && acc >= abort_rows) break;
        end
        ref_valid = 1'b0;
        cur_valid = 1'b0;
        start     = 1'b0;
        if (abort_rows > 0) return;
        check("search_cands", k, NC);
        check("drain_cycle", cyc, last_t + 1);
        check("drain_ref_ready", ref_ready, 0);
        check("drain_busy", busy, 1);
        check("drain_best_valid", best_valid, 0);
        @(negedge clk);
        check("drain_best_valid_t2", best_valid, 0);
        @(negedge clk);
        model_best(bs, bi);
        check("best_valid_t3", best_valid, 1);
        check("busy_t3", busy, 0);
        check("best_sad", best_sad, bs);
        check("best_idx", best_idx, bi);
        check("pending_pulses", exp_q.size(), 0);
    endtask

    task automatic fill_const(input logic [7:0] cv, input logic [7:0] rv);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                cur_px[r][c] = cv;
                for (int k = 0; k < NC; k++) ref_px[k][r][c] = rv;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                cur_px[r][c] = 8'($urandom);
                for (int k = 0; k < NC; k++) ref_px[k][r][c] = 8'($urandom);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*QW-1:0] qlit;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Identical blocks: every SAD is zero, best is candidate 0.
        fill_const(8'h10, 8'h10);
        run_search(1'b0, 1'b0, 0);
        for (int k = 0; k < NC; k++) check("lit_zero_sad", got_sad[k], 0);
        check("lit_zero_best", best_sad, 0);
        check("lit_zero_best_idx", best_idx, 0);

        // Maximum-difference candidate: no overflow in full or quadrant sums.
        fill_const(8'h00, 8'h00);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                ref_px[0][r][c] = 8'hFF;
                for (int k = 1; k < NC; k++) ref_px[k][r][c] = 8'($urandom);
            end
        run_search(1'b0, 1'b0, 0);
        qlit = {4{14'd16320}};
        check("lit_max_sad", got_sad[0], 65280);
        check("lit_max_quad", got_quad[0], qlit);

        // SADs 300, 100, 250, 100: the tie keeps index 1.
        fill_const(8'h00, 8'h00);
        ref_px[0][0][0] = 8'd255;
        ref_px[0][0][1] = 8'd45;
        ref_px[1][0][0] = 8'd100;
        ref_px[2][5][9] = 8'd250;
        ref_px[3][8][8] = 8'd100;
        run_search(1'b0, 1'b0, 0);
        check("lit_tie_sad0", got_sad[0], 300);
        check("lit_tie_sad1", got_sad[1], 100);
        check("lit_tie_sad2", got_sad[2], 250);
        check("lit_tie_sad3", got_sad[3], 100);
        check("lit_tie_best", best_sad, 100);
        check("lit_tie_best_idx", best_idx, 1);

        // Single +5 pixel in the bottom-left quadrant of candidate 2.
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                cur_px[r][c] = 8'($urandom_range(0, 250));
                for (int k = 0; k < NC; k++) ref_px[k][r][c] = cur_px[r][c];
            end
        ref_px[2][12][3] = cur_px[12][3] + 8'd5;
        run_search(1'b0, 1'b0, 0);
        qlit = {14'd0, 14'd5, 14'd0, 14'd0};
        check("lit_q2_sad", got_sad[2], 5);
        check("lit_q2_quad", got_quad[2], qlit);

        // Random data with handshake gaps, then the same data back-to-back.
        fill_random();
        run_search(1'b1, 1'b0, 0);
        run_search(1'b0, 1'b0, 0);

        // Reset in the middle of SEARCH, then a noisy-start rerun of the same data.
        run_search(1'b0, 1'b0, 2 * MD + 7);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_search(1'b1, 1'b1, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_block_search.md
# sad_block_search

Parametrised successor to the current pixel-level absolute-difference matrix. It stores one current macroblock and streams reference candidates row by row. For each candidate it accumulates the full-block SAD and four quadrant SADs, and it tracks the best (minimum-SAD) candidate. It sits in the inter-prediction path between the search-window fetch logic and the motion-vector decision stage, so downstream logic no longer has to sum raw absolute differences.

## Interface
- MACRO_DIM, 16, block edge in pixels; even, ≥4, power of two
- PIXEL_W, 8, bits per pixel
- NUM_CAND, 1024, candidates per search; ≥1
- CAND_W, $clog2(NUM_CAND) (min 1), candidate index width
- SAD_W, PIXEL_W+2*$clog2(MACRO_DIM), full SAD width
- QSAD_W, PIXEL_W+2*$clog2(MACRO_DIM/2), quadrant SAD width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin new search; accepted only in IDLE
- cur_valid  in  1  current-block row valid
- cur_ready  out  1  high only in LOAD
- cur_row  in  PIXEL_W*MACRO_DIM  current row; pixel j at bits [j*PIXEL_W +: PIXEL_W]
- ref_valid  in  1  reference row valid
- ref_ready  out  1  high only in SEARCH
- ref_row  in  PIXEL_W*MACRO_DIM  candidate row, same packing
- sad_valid  out  1  one-cycle pulse per finished candidate
- sad  out  SAD_W  full-block SAD of the finished candidate
- sad_quad  out  4*QSAD_W  quadrant SADs: q0 top-left, q1 top-right, q2 bottom-left, q3 bottom-right; qk at [k*QSAD_W +: QSAD_W]
- sad_idx  out  CAND_W  index of the finished candidate
- best_valid  out  1  level; high from search end until next accepted start
- best_sad  out  SAD_W  minimum SAD
- best_idx  out  CAND_W  index of the minimum
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, SEARCH, DRAIN.
- IDLE: start → LOAD. This clears best_valid, row counter and candidate counter, and sets the best register to all-ones.
- LOAD: each cur_valid&&cur_ready handshake writes cur_row into current-block row r, r = 0..MACRO_DIM-1. After row MACRO_DIM-1 → SEARCH.
- SEARCH: each ref_valid&&ref_ready handshake is paired with current row r (r counts 0..MACRO_DIM-1 per candidate, then wraps to 0).
  - A candidate = MACRO_DIM consecutive accepted rows.
  - After the last row of candidate NUM_CAND-1 → DRAIN.
- Stage 1 (registered): per-pixel |ref−cur| using unsigned PIXEL_W math. Left-half and right-half row sums are each (PIXEL_W+$clog2(MACRO_DIM/2)) bits.
- Stage 2 (registered): add the half sums into the quadrant accumulators, using r < MACRO_DIM/2 to select top or bottom. Clear accumulators on a candidate's first row (load, not add).
- Full SAD = q0+q1+q2+q3. No saturation: widths are exact, so overflow is impossible.
- Best update happens when sad_valid is high and sad < best_sad (strict). On ties the lower index wins.
- DRAIN: wait until the last candidate's sad_valid and best update complete. Then set best_valid and → IDLE.
- start outside IDLE is ignored. cur_valid outside LOAD and ref_valid outside SEARCH are ignored.

## Timing
- Reset values: every output is 0 except cur_ready=0, ref_ready=0 and busy=0. The best_sad register resets to 0 and is preset to all-ones on start. The FSM resets to IDLE. The current-block store need not be reset.
- start sampled in cycle t: busy=1 and cur_ready=1 from t+1.
- Last row of a candidate accepted in cycle T: sad_valid, sad, sad_quad and sad_idx are valid in cycle T+2, as a single-cycle pulse.
- Last candidate's last row accepted in cycle T: ref_ready=0 from T+1. best_valid=1 with final best_sad/best_idx at T+3. busy=0 at T+3.
- Gaps in ref_valid stall the pipeline front only. Latency is measured from the accepting edge.
- Back-to-back rows give full throughput: one candidate every MACRO_DIM cycles. sad_valid pulses may then be MACRO_DIM cycles apart with no dead cycle.
- rst_n asserted in any state: everything returns to reset values immediately (asynchronously). The next search requires a fresh start and a full LOAD.

## Test plan
- M=16, PIXEL_W=8, NUM_CAND=4; current block all 0x10, all candidates 0x10 → every sad=0, best_sad=0, best_idx=0, best_valid at T+3.
- Current block all 0x00, candidate 0 all 0xFF → sad=65280, each quadrant=16320, sad_idx=0; no overflow.
- Candidate SADs 300, 100, 250, 100 → best_sad=100, best_idx=1 (tie keeps the lower index).
- Candidate 2 differs only by +5 on pixel (row 12, col 3) → q2=5, q0=q1=q3=0, sad=5.
- Random ref_valid gaps with back-to-back sections → results match the gap-free run. sad_valid falls 2 cycles after each last accepted row.
- rst_n pulsed mid-SEARCH, plus start asserted while busy → outputs zero and start is ignored respectively. A new start after reset reproduces the golden results.
